// File: rtl/smol_dec_pkg.sv
// Shared types for the SmolCore decode stage: format codes, opcodes and the
// decoded-entry payload held in the output slot and the skid register.
package smol_dec_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned PC_W_MAX = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_U    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_R    = 3'd4,
        FMT_J    = 3'd5,
        FMT_B    = 3'd6,
        FMT_X    = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    // Sized for the widest configuration; narrower builds use the low bits.
    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        fmt_e                fmt;
        logic [XLEN_MAX-1:0] imm;
        logic                illegal;
    } dec_entry_t;

endpackage

// File: rtl/smol_dec_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface smol_dec_if
    import smol_dec_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [6:0]         out_opcode;
    logic [4:0]         out_rd;
    logic [4:0]         out_rs1;
    logic [4:0]         out_rs2;
    logic [2:0]         out_funct3;
    logic [6:0]         out_funct7;
    fmt_e               out_fmt;
    logic [XLEN-1:0]    out_imm;
    logic               out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_fmt, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_fmt, out_imm, out_illegal
    );
endinterface

// File: rtl/smol_imm_gen.sv
// Combinational format classifier, immediate generator and legality check
// for one RV32I/RV64I instruction word.
module smol_imm_gen
    import smol_dec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] i_instr,
    output fmt_e               o_fmt,
    output logic [XLEN-1:0]    o_imm,
    output logic               o_illegal
);
    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_s;
    logic        w_shift;
    logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    fmt_e        w_fmt;
    logic [63:0] w_imm;
    logic        w_bad;

    assign w_opc   = i_instr[6:0];
    assign w_f3    = i_instr[14:12];
    assign w_s     = i_instr[31];
    assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    assign w_imm_i = {{52{w_s}}, i_instr[31:20]};
    assign w_imm_s = {{52{w_s}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{51{w_s}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {{32{w_s}}, i_instr[31:12], 12'b0};
    assign w_imm_j = {{43{w_s}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Opcodes outside the table also catch instr[1:0] != 2'b11.
    always_comb begin
        w_fmt = FMT_X;
        w_imm = '0;
        w_bad = 1'b0;
        case (w_opc)
            OPC_LUI, OPC_AUIPC: begin
                w_fmt = FMT_U;
                w_imm = w_imm_u;
            end
            OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: begin
                w_fmt = FMT_I;
                w_imm = w_imm_i;
            end
            OPC_JALR: begin
                w_fmt = FMT_I;
                w_imm = w_imm_i;
                w_bad = (w_f3 != 3'b000);
            end
            OPC_OP_IMM: begin
                w_fmt = FMT_I;
                if (w_shift) begin
                    w_imm = RV64 ? 64'(i_instr[25:20]) : 64'(i_instr[24:20]);
                    w_bad = !RV64 && i_instr[25];
                end else begin
                    w_imm = w_imm_i;
                end
            end
            OPC_OP_IMM32: begin
                if (RV64) begin
                    w_fmt = FMT_I;
                    w_imm = w_shift ? 64'(i_instr[24:20]) : w_imm_i;
                end else begin
                    w_bad = 1'b1;
                end
            end
            OPC_STORE: begin
                w_fmt = FMT_S;
                w_imm = w_imm_s;
            end
            OPC_OP: w_fmt = FMT_R;
            OPC_OP32: begin
                if (RV64) w_fmt = FMT_R;
                else      w_bad = 1'b1;
            end
            OPC_JAL: begin
                w_fmt = FMT_J;
                w_imm = w_imm_j;
            end
            OPC_BRANCH: begin
                w_fmt = FMT_B;
                w_imm = w_imm_b;
                w_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign o_illegal = w_bad;
    assign o_fmt     = w_bad ? FMT_X : w_fmt;
    assign o_imm     = w_bad ? '0 : XLEN'(w_imm);

endmodule

// File: rtl/smol_dec_stage.sv
// SmolCore decode stage: decodes the arriving word, registers it into the
// output slot, and parks one extra entry in a skid register under backpressure.
module smol_dec_stage
    import smol_dec_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    smol_dec_if.slave  bus
);
    fmt_e            w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;

    dec_entry_t w_dec;
    dec_entry_t r_slot, r_skid;
    dec_entry_t w_slot_nxt, w_skid_nxt;
    logic       r_valid, r_skid_full;
    logic       w_valid_nxt, w_skid_full_nxt;
    logic       w_in_xfer, w_out_xfer, w_slot_free;

    smol_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr   (bus.in_instr),
        .o_fmt     (w_fmt),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = PC_W_MAX'(bus.in_pc);
        w_dec.opcode  = bus.in_instr[6:0];
        w_dec.rd      = bus.in_instr[11:7];
        w_dec.funct3  = bus.in_instr[14:12];
        w_dec.rs1     = bus.in_instr[19:15];
        w_dec.rs2     = bus.in_instr[24:20];
        w_dec.funct7  = bus.in_instr[31:25];
        w_dec.fmt     = w_fmt;
        w_dec.imm     = XLEN_MAX'(w_imm);
        w_dec.illegal = w_illegal;
    end

    // in_ready comes straight off the skid-full flop.
    assign w_in_xfer   = bus.in_valid && !r_skid_full && !flush;
    assign w_out_xfer  = r_valid && bus.out_ready;
    assign w_slot_free = !r_valid || w_out_xfer;

    always_comb begin
        w_slot_nxt      = r_slot;
        w_skid_nxt      = r_skid;
        w_valid_nxt     = r_valid;
        w_skid_full_nxt = r_skid_full;
        if (flush) begin
            w_valid_nxt     = 1'b0;
            w_skid_full_nxt = 1'b0;
        end else if (w_slot_free) begin
            if (r_skid_full) begin
                w_slot_nxt      = r_skid;
                w_valid_nxt     = 1'b1;
                w_skid_full_nxt = 1'b0;
            end else begin
                w_valid_nxt = w_in_xfer;
                if (w_in_xfer) w_slot_nxt = w_dec;
            end
        end else if (w_in_xfer) begin
            w_skid_nxt      = w_dec;
            w_skid_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot      <= '0;
            r_skid      <= '0;
            r_valid     <= 1'b0;
            r_skid_full <= 1'b0;
        end else begin
            r_slot      <= w_slot_nxt;
            r_skid      <= w_skid_nxt;
            r_valid     <= w_valid_nxt;
            r_skid_full <= w_skid_full_nxt;
        end
    end

    assign bus.in_ready    = !r_skid_full;
    assign bus.out_valid   = r_valid;
    assign bus.out_pc      = PC_W'(r_slot.pc);
    assign bus.out_opcode  = r_slot.opcode;
    assign bus.out_rd      = r_slot.rd;
    assign bus.out_rs1     = r_slot.rs1;
    assign bus.out_rs2     = r_slot.rs2;
    assign bus.out_funct3  = r_slot.funct3;
    assign bus.out_funct7  = r_slot.funct7;
    assign bus.out_fmt     = r_slot.fmt;
    assign bus.out_imm     = XLEN'(r_slot.imm);
    assign bus.out_illegal = r_slot.illegal;

endmodule

// File: doc/smol_dec_stage.md
Name: smol_dec_stage

Overview:
- Registered, handshaked decode stage for SmolCore.
- Sits between fetch and register-read/execute.
- Accepts a 32-bit instruction word with its PC; outputs decoded fields, a format code, an XLEN-wide immediate and an illegal flag one cycle later.
- Generalised over XLEN (RV32I/RV64I). An internal 2-entry skid buffer keeps full throughput under backpressure, and a flush drops in-flight instructions.

Parameters:
- XLEN, 32, datapath width of the immediate; legal values 32 or 64.
- PC_W, 32, width of the PC carried alongside the instruction.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drop all held and arriving instructions this cycle
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; registered, equals !skid_full
- in_instr  in  32  raw instruction word
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  PC of decoded entry
- out_opcode  out  7  instr[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_fmt  out  3  format code, values in the smol_dec_pkg enum
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  instruction not legal for the configured XLEN

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, skid empty, and every data output 0.
- Decode is combinational on in_instr. The result is registered into the output slot, so latency is 1 cycle: accepted at edge N, visible after edge N.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Output slot load: if the slot is empty, or it transfers this cycle, it loads from skid when skid is full, else from the input.
  - Skid capture: if the input transfers while the slot is held (out_valid && !out_ready), the decoded input is written to skid and in_ready drops on the next cycle.
  - Throughput: 1 instruction/cycle when out_ready stays high.
  - Ordering: strictly in order; no entry is duplicated or lost.
- Output stability: while out_valid && !out_ready, every out_* signal is stable.
- Format codes:
  - U=1: LUI 0110111, AUIPC 0010111.
  - I=2: LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111, JALR 1100111, SYSTEM 1110011; OP-IMM-32 0011011 when XLEN=64.
  - S=3: STORE 0100011.
  - R=4: OP 0110011; OP-32 0111011 when XLEN=64.
  - J=5: JAL 1101111.
  - B=6: BRANCH 1100011.
  - X=7: everything else.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Shift exception: OP-IMM with funct3 001/101 gives imm = zero-extended shamt, instr[24:20] for RV32 or instr[25:20] for RV64. OP-IMM-32 shifts always use 5 bits.
  - R and X formats give imm=0.
- Illegal (out_fmt forced to X, out_imm forced to 0, other fields pass through) when any of:
  - instr[1:0] != 2'b11;
  - the opcode is not listed above;
  - JALR with funct3 != 000;
  - BRANCH with funct3 010 or 011;
  - RV32 shift-immediate with instr[25]=1.
  - Illegal entries still handshake normally.
- Flush:
  - Synchronous; clears out_valid and skid, and blocks any input transfer that cycle (the instruction is discarded).
  - in_ready is 1 on the next cycle.
  - Flush has priority over every simultaneous transfer.
- Reset mid-operation: all held entries are lost immediately; there is no partial output.

Decomposition:
- smol_dec_pkg holds:
  - the fmt_e enum (3-bit);
  - opcode localparams (OPC_LUI … OPC_OP32);
  - the decoded-entry struct dec_entry_t {pc, fields, fmt, imm, illegal}, parametrised via XLEN/PC_W localparams.
- One combinational sub-module, smol_imm_gen: instr and XLEN in; fmt, imm and illegal out.
- The top module owns the output register, the skid register and the handshake.

Test Plan:
- Decode spot-checks, XLEN=32, out_ready=1:
  - 0xFFF00093 → fmt=I, rd=1, imm=0xFFFFFFFF.
  - 0x123452B7 → fmt=U, rd=5, imm=0x12345000.
  - 0xFE000EE3 → fmt=B, imm=0xFFFFFFFC.
  - 0x001000EF → fmt=J, rd=1, imm=0x00000800.
- Illegal and XLEN cases:
  - 0x0000007F → illegal=1, fmt=X, imm=0.
  - RV32 srai 0x4210D093 (bit25=1) → illegal=1.
  - Same word at XLEN=64 → fmt=I, imm=0x21.
  - At XLEN=64, 0xFFF0009B → fmt=I, imm=0xFFFFFFFFFFFFFFFF.
- Backpressure: stream 8 instructions with in_valid=1 while out_ready toggles 1,0,0,1…
  - in_ready drops exactly one cycle after the first held capture.
  - All 8 PCs emerge in order with no duplicates.
  - Outputs stay stable while held.
- Flush: with slot and skid both full, assert flush alongside in_valid → next cycle out_valid=0 and in_ready=1; the flushed PCs never appear.
- Reset mid-stream: drop rst_n asynchronously with the skid full → out_valid=0 and in_ready=1 immediately; the first instruction after release appears with 1-cycle latency.
